// File: rtl/xv_pkg.sv
// Shared Xosera video definitions: SCANLINE status layout, frame counter type
// and the default 640x480 mode timing used as parameter defaults.
package xv_pkg;

  // SCANLINE status word layout
  localparam int unsigned SCANLINE_VBLANK_BIT = 15;
  localparam int unsigned SCANLINE_HBLANK_BIT = 14;
  localparam int unsigned SCANLINE_V_W        = 11;

  typedef logic [7:0]  frame_count_t;
  typedef logic [15:0] scanline_t;

  // Default mode: 640x480 @ 60 Hz, 25.175 MHz pixel clock
  localparam int unsigned MODE_VISIBLE_WIDTH   = 640;
  localparam int unsigned MODE_VISIBLE_HEIGHT  = 480;
  localparam int unsigned MODE_H_FRONT_PORCH   = 16;
  localparam int unsigned MODE_H_SYNC_PULSE    = 96;
  localparam int unsigned MODE_H_BACK_PORCH    = 48;
  localparam int unsigned MODE_V_FRONT_PORCH   = 10;
  localparam int unsigned MODE_V_SYNC_PULSE    = 2;
  localparam int unsigned MODE_V_BACK_PORCH    = 33;
  localparam logic        MODE_H_SYNC_POLARITY = 1'b0;
  localparam logic        MODE_V_SYNC_POLARITY = 1'b0;
  localparam int unsigned MODE_COORD_W         = 11;

  // Total positions along one axis (visible + porches + sync)
  function automatic int unsigned axis_total(input int unsigned vis, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return vis + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_axis_cnt.sv
// One raster axis: wrapping position counter with registered blank/sync/last
// flags decoded from the next-state count, so flags line up with count.
module video_axis_cnt
  import xv_pkg::*;
#(
  parameter int unsigned VISIBLE = MODE_VISIBLE_WIDTH,
  parameter int unsigned FP      = MODE_H_FRONT_PORCH,
  parameter int unsigned SYNC    = MODE_H_SYNC_PULSE,
  parameter int unsigned BP      = MODE_H_BACK_PORCH,
  parameter logic        POL     = MODE_H_SYNC_POLARITY,
  parameter int unsigned W       = MODE_COORD_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         advance,
  input  logic         restart,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next,
  output logic         blank,
  output logic         blank_next,
  output logic         sync,
  output logic         last,
  output logic         last_next
);

  localparam int unsigned Total     = axis_total(VISIBLE, FP, SYNC, BP);
  localparam int unsigned SyncStart = VISIBLE + FP;
  localparam int unsigned SyncEnd   = VISIBLE + FP + SYNC;
  localparam logic [W-1:0] LastPos  = W'(Total - 1);

  logic [W-1:0] count_q, count_d;
  logic         blank_q, blank_d;
  logic         sync_q, sync_d;
  logic         last_q, last_d;
  logic [31:0]  next_ext;

  // Next position: restart parks on the last position, otherwise step and wrap
  always_comb begin
    count_d = count_q;
    if (restart) begin
      count_d = LastPos;
    end else if (advance) begin
      count_d = last_q ? '0 : count_q + W'(1);
    end
  end

  // Flags decoded from the next position so they register alongside it
  always_comb begin
    next_ext = 32'(count_d);
    blank_d  = next_ext >= VISIBLE;
    sync_d   = (next_ext >= SyncStart && next_ext < SyncEnd) ? POL : ~POL;
    last_d   = next_ext == Total - 1;
  end

  // Axis state; reset parks on the last position with sync inactive
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= LastPos;
      blank_q <= 1'b1;
      sync_q  <= ~POL;
      last_q  <= 1'b1;
    end else begin
      count_q <= count_d;
      blank_q <= blank_d;
      sync_q  <= sync_d;
      last_q  <= last_d;
    end
  end

  assign count      = count_q;
  assign count_next = count_d;
  assign blank      = blank_q;
  assign blank_next = blank_d;
  assign sync       = sync_q;
  assign last       = last_q;
  assign last_next  = last_d;

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: H/V coordinates, sync/blank/visible
// flags, line/frame strobes, frame counter and SCANLINE status word.
// Optional line-compare interrupt enabled by defining VTG_LINE_IRQ_EN.
module video_timing_gen
  import xv_pkg::*;
#(
  parameter int unsigned VISIBLE_WIDTH   = MODE_VISIBLE_WIDTH,
  parameter int unsigned VISIBLE_HEIGHT  = MODE_VISIBLE_HEIGHT,
  parameter int unsigned H_FRONT_PORCH   = MODE_H_FRONT_PORCH,
  parameter int unsigned H_SYNC_PULSE    = MODE_H_SYNC_PULSE,
  parameter int unsigned H_BACK_PORCH    = MODE_H_BACK_PORCH,
  parameter int unsigned V_FRONT_PORCH   = MODE_V_FRONT_PORCH,
  parameter int unsigned V_SYNC_PULSE    = MODE_V_SYNC_PULSE,
  parameter int unsigned V_BACK_PORCH    = MODE_V_BACK_PORCH,
  parameter logic        H_SYNC_POLARITY = MODE_H_SYNC_POLARITY,
  parameter logic        V_SYNC_POLARITY = MODE_V_SYNC_POLARITY,
  parameter int unsigned COORD_W         = MODE_COORD_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               restart_i,
  input  logic               line_cmp_en_i,
  input  logic [COORD_W-1:0] line_cmp_i,
  output logic [COORD_W-1:0] h_count_o,
  output logic [COORD_W-1:0] v_count_o,
  output logic               visible_o,
  output logic               hblank_o,
  output logic               vblank_o,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               end_of_line_o,
  output logic               end_of_frame_o,
  output frame_count_t       frame_count_o,
  output scanline_t          scanline_o,
  output logic               line_irq_o
);

  localparam int unsigned TOTAL_WIDTH  =
      axis_total(VISIBLE_WIDTH, H_FRONT_PORCH, H_SYNC_PULSE, H_BACK_PORCH);
  localparam int unsigned TOTAL_HEIGHT =
      axis_total(VISIBLE_HEIGHT, V_FRONT_PORCH, V_SYNC_PULSE, V_BACK_PORCH);

  if ((64'd1 << COORD_W) < 64'(TOTAL_WIDTH) ||
      (64'd1 << COORD_W) < 64'(TOTAL_HEIGHT)) begin : g_coord_w_check
    $error("video_timing_gen: COORD_W too narrow for total width/height");
  end

  logic [COORD_W-1:0] h_count_next, v_count_next;
  logic               h_blank_next, v_blank_next;
  logic               h_last, h_last_next, v_last_next;
  logic               v_last_unused;

  video_axis_cnt #(
    .VISIBLE (VISIBLE_WIDTH),
    .FP      (H_FRONT_PORCH),
    .SYNC    (H_SYNC_PULSE),
    .BP      (H_BACK_PORCH),
    .POL     (H_SYNC_POLARITY),
    .W       (COORD_W)
  ) u_h_axis (
    .clk        (clk),
    .reset_n    (reset_n),
    .advance    (1'b1),
    .restart    (restart_i),
    .count      (h_count_o),
    .count_next (h_count_next),
    .blank      (hblank_o),
    .blank_next (h_blank_next),
    .sync       (hsync_o),
    .last       (h_last),
    .last_next  (h_last_next)
  );

  // Vertical axis steps when the horizontal axis sits on its last pixel
  video_axis_cnt #(
    .VISIBLE (VISIBLE_HEIGHT),
    .FP      (V_FRONT_PORCH),
    .SYNC    (V_SYNC_PULSE),
    .BP      (V_BACK_PORCH),
    .POL     (V_SYNC_POLARITY),
    .W       (COORD_W)
  ) u_v_axis (
    .clk        (clk),
    .reset_n    (reset_n),
    .advance    (h_last),
    .restart    (restart_i),
    .count      (v_count_o),
    .count_next (v_count_next),
    .blank      (vblank_o),
    .blank_next (v_blank_next),
    .sync       (vsync_o),
    .last       (v_last_unused),
    .last_next  (v_last_next)
  );

  logic         visible_q, visible_d;
  logic         eol_q, eol_d;
  logic         eof_q, eof_d;
  frame_count_t frame_q, frame_d;

  // Strobes and frame counter next state; restart masks strobes and holds the count
  always_comb begin
    visible_d = ~h_blank_next & ~v_blank_next;
    eol_d     = h_last_next & ~restart_i;
    eof_d     = eol_d & v_last_next;
    frame_d   = frame_q;
    if (eof_q && !restart_i) begin
      frame_d = frame_q + frame_count_t'(1);
    end
  end

  // Visible flag, strobes and frame counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      visible_q <= 1'b0;
      eol_q     <= 1'b0;
      eof_q     <= 1'b0;
      frame_q   <= '0;
    end else begin
      visible_q <= visible_d;
      eol_q     <= eol_d;
      eof_q     <= eof_d;
      frame_q   <= frame_d;
    end
  end

  assign visible_o      = visible_q;
  assign end_of_line_o  = eol_q;
  assign end_of_frame_o = eof_q;
  assign frame_count_o  = frame_q;

`ifdef VTG_LINE_IRQ_EN
  logic irq_q, irq_d;

  // Fire on entry to hblank of the compare line; out-of-range lines never match
  always_comb begin
    irq_d = ~restart_i & line_cmp_en_i & (v_count_next == line_cmp_i) &
            (32'(h_count_next) == VISIBLE_WIDTH);
  end

  // Line-compare interrupt register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign line_irq_o = irq_q;
`else
  logic unused_cmp;
  assign unused_cmp = ^{line_cmp_en_i, line_cmp_i, h_count_next, v_count_next};
  assign line_irq_o = 1'b0;
`endif

  // SCANLINE status word: pure wiring of registered flags and line number
  always_comb begin
    scanline_o                               = '0;
    scanline_o[SCANLINE_VBLANK_BIT]          = vblank_o;
    scanline_o[SCANLINE_HBLANK_BIT]          = hblank_o;
    scanline_o[SCANLINE_V_W-1:0]             = SCANLINE_V_W'(v_count_o);
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen using a small 14x8 raster
// (8 visible + 2 FP + 3 sync + 1 BP, 4 visible + 1 FP + 2 sync + 1 BP).
module tb_video_timing_gen;

  localparam int unsigned CW = 5;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          restart;
  logic          cmp_en;
  logic [CW-1:0] cmp;
  logic [CW-1:0] h, v;
  logic          vis, hb, vb, hs, vs, eol, eof, irq;
  logic [7:0]    fc;
  logic [15:0]   scan;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  always #5 clk = ~clk;

  video_timing_gen #(
    .VISIBLE_WIDTH   (8),
    .VISIBLE_HEIGHT  (4),
    .H_FRONT_PORCH   (2),
    .H_SYNC_PULSE    (3),
    .H_BACK_PORCH    (1),
    .V_FRONT_PORCH   (1),
    .V_SYNC_PULSE    (2),
    .V_BACK_PORCH    (1),
    .H_SYNC_POLARITY (1'b0),
    .V_SYNC_POLARITY (1'b1),
    .COORD_W         (CW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .restart_i      (restart),
    .line_cmp_en_i  (cmp_en),
    .line_cmp_i     (cmp),
    .h_count_o      (h),
    .v_count_o      (v),
    .visible_o      (vis),
    .hblank_o       (hb),
    .vblank_o       (vb),
    .hsync_o        (hs),
    .vsync_o        (vs),
    .end_of_line_o  (eol),
    .end_of_frame_o (eof),
    .frame_count_o  (fc),
    .scanline_o     (scan),
    .line_irq_o     (irq)
  );

  typedef struct {
    int unsigned clocks;
    logic [4:0]  h, v;
    logic        hb, vb, vis, hs, vs, eol, eof;
    logic [7:0]  fc;
    logic [15:0] scan;
  } vec_t;

  vec_t vecs[14];

`ifdef VTG_LINE_IRQ_EN
  localparam logic IrqBuilt = 1'b1;
`else
  localparam logic IrqBuilt = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_park(input string tag, input logic [7:0] exp_fc);
    check({tag, " h"}, 64'(h), 64'd13);
    check({tag, " v"}, 64'(v), 64'd7);
    check({tag, " flags"}, 64'({hb, vb, vis, hs, vs, eol, eof, irq}), 64'b11010000);
    check({tag, " fc"}, 64'(fc), 64'(exp_fc));
    check({tag, " scan"}, 64'(scan), 64'hC007);
  endtask

  int unsigned eh, ev;
  logic [7:0]  efc;
  logic        f_en[3];
  logic [4:0]  f_cmp[3];

  initial begin
    //            clk  h      v     hb vb vis hs vs eol eof fc     scan
    vecs[0]  = '{0,  5'd13, 5'd7, 1, 1, 0,  1, 0, 0,  0,  8'd0, 16'hC007};
    vecs[1]  = '{1,  5'd0,  5'd0, 0, 0, 1,  1, 0, 0,  0,  8'd0, 16'h0000};
    vecs[2]  = '{7,  5'd7,  5'd0, 0, 0, 1,  1, 0, 0,  0,  8'd0, 16'h0000};
    vecs[3]  = '{1,  5'd8,  5'd0, 1, 0, 0,  1, 0, 0,  0,  8'd0, 16'h4000};
    vecs[4]  = '{2,  5'd10, 5'd0, 1, 0, 0,  0, 0, 0,  0,  8'd0, 16'h4000};
    vecs[5]  = '{2,  5'd12, 5'd0, 1, 0, 0,  0, 0, 0,  0,  8'd0, 16'h4000};
    vecs[6]  = '{1,  5'd13, 5'd0, 1, 0, 0,  1, 0, 1,  0,  8'd0, 16'h4000};
    vecs[7]  = '{1,  5'd0,  5'd1, 0, 0, 1,  1, 0, 0,  0,  8'd0, 16'h0001};
    vecs[8]  = '{42, 5'd0,  5'd4, 0, 1, 0,  1, 0, 0,  0,  8'd0, 16'h8004};
    vecs[9]  = '{14, 5'd0,  5'd5, 0, 1, 0,  1, 1, 0,  0,  8'd0, 16'h8005};
    vecs[10] = '{14, 5'd0,  5'd6, 0, 1, 0,  1, 1, 0,  0,  8'd0, 16'h8006};
    vecs[11] = '{14, 5'd0,  5'd7, 0, 1, 0,  1, 0, 0,  0,  8'd0, 16'h8007};
    vecs[12] = '{13, 5'd13, 5'd7, 1, 1, 0,  1, 0, 1,  1,  8'd0, 16'hC007};
    vecs[13] = '{1,  5'd0,  5'd0, 0, 0, 1,  1, 0, 0,  0,  8'd1, 16'h0000};

    f_en[0] = 1'b1; f_cmp[0] = 5'd2;
    f_en[1] = 1'b0; f_cmp[1] = 5'd2;
    f_en[2] = 1'b1; f_cmp[2] = 5'd9;

    reset_n = 1'b0;
    restart = 1'b0;
    cmp_en  = 1'b0;
    cmp     = '0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;

    // Table: reset state then hand-computed points through the first frame
    for (int i = 0; i < 14; i++) begin
      repeat (vecs[i].clocks) step();
      check($sformatf("vec%0d h", i), 64'(h), 64'(vecs[i].h));
      check($sformatf("vec%0d v", i), 64'(v), 64'(vecs[i].v));
      check($sformatf("vec%0d flags", i), 64'({hb, vb, vis, hs, vs, eol, eof, irq}),
            64'({vecs[i].hb, vecs[i].vb, vecs[i].vis, vecs[i].hs, vecs[i].vs,
                 vecs[i].eol, vecs[i].eof, 1'b0}));
      check($sformatf("vec%0d fc", i), 64'(fc), 64'(vecs[i].fc));
      check($sformatf("vec%0d scan", i), 64'(scan), 64'(vecs[i].scan));
    end

    // Three full frames checked every cycle; compare setup varies per frame
    eh = 0; ev = 0; efc = 8'd1;
    for (int f = 0; f < 3; f++) begin
      cmp_en = f_en[f];
      cmp    = f_cmp[f];
      for (int c = 0; c < 112; c++) begin
        logic e_hb, e_vb, e_hs, e_vs, e_eol, e_eof, e_irq;
        step();
        eh++;
        if (eh == 14) begin
          eh = 0;
          ev++;
          if (ev == 8) ev = 0;
        end
        if (eh == 0 && ev == 0) efc++;
        e_hb  = eh >= 8;
        e_vb  = ev >= 4;
        e_hs  = !(eh >= 10 && eh < 13);
        e_vs  = (ev >= 5 && ev < 7);
        e_eol = eh == 13;
        e_eof = e_eol && ev == 7;
        e_irq = IrqBuilt && f_en[f] && (32'(f_cmp[f]) == ev) && eh == 8;
        check($sformatf("run f%0d h%0d v%0d", f, eh, ev),
              {22'd0, h, v, hb, vb, vis, hs, vs, eol, eof, irq, fc, scan},
              {22'd0, 5'(eh), 5'(ev), e_hb, e_vb, !e_hb && !e_vb, e_hs, e_vs, e_eol, e_eof,
               e_irq, efc, e_vb, e_hb, 9'd0, 5'(ev)});
      end
    end
    cmp_en = 1'b0;
    check("fc after 3 frames", 64'(fc), 64'd4);

    // Frame counter wrap 255 -> 0
    repeat (251 * 112) step();
    check("fc preload", 64'(fc), 64'd255);
    repeat (111) step();
    check("eof before wrap", 64'({eol, eof, fc}), 64'({2'b11, 8'd255}));
    step();
    check("fc wrap", 64'(fc), 64'd0);
    check("pos after wrap", 64'({h, v}), 64'd0);
    repeat (112) step();
    check("fc one", 64'(fc), 64'd1);

    // Restart mid-frame, also masking a pending line irq
    cmp_en = 1'b1;
    cmp    = 5'd2;
    repeat (35) step();
    check("pre-restart pos", 64'({h, v}), 64'({5'd7, 5'd2}));
    restart = 1'b1;
    step();
    check_park("restart", 8'd1);
    step();
    check_park("restart held", 8'd1);
    restart = 1'b0;
    cmp_en  = 1'b0;
    step();
    check("post-restart pos", 64'({h, v, vis}), 64'({5'd0, 5'd0, 1'b1}));
    check("post-restart fc", 64'(fc), 64'd1);

    // Restart on the would-be end-of-frame cycle suppresses strobes and increment
    repeat (110) step();
    check("pre-eof pos", 64'({h, v}), 64'({5'd12, 5'd7}));
    restart = 1'b1;
    step();
    check_park("restart at eof", 8'd1);
    restart = 1'b0;
    step();
    check("no fc bump", 64'({h, v, fc}), 64'({5'd0, 5'd0, 8'd1}));

    // Asynchronous reset mid-line
    repeat (5) step();
    check("pre-reset h", 64'(h), 64'd5);
    #3 reset_n = 1'b0;
    #1;
    check_park("async reset", 8'd0);
    #2 reset_n = 1'b1;
    step();
    check("post-reset pos", 64'({h, v, vis, fc}), 64'({5'd0, 5'd0, 1'b1, 8'd0}));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised raster timing generator for the Xosera video path; replaces fixed, macro-selected mode constants with per-instance timing parameters.
- Produces H/V pixel coordinates, sync, blank and visible flags, line/frame strobes, frame counter and the SCANLINE status word.
- Optionally raises a programmable line-compare interrupt.
- Sits between the pixel-clock domain and the tile/pixel fetch logic; the AUX_VID read path consumes scanline_o.

Parameters:
- VISIBLE_WIDTH, 640, active pixels per line
- VISIBLE_HEIGHT, 480, active lines
- H_FRONT_PORCH, 16, pixels
- H_SYNC_PULSE, 96, pixels
- H_BACK_PORCH, 48, pixels
- V_FRONT_PORCH, 10, lines
- V_SYNC_PULSE, 2, lines
- V_BACK_PORCH, 33, lines
- H_SYNC_POLARITY, 1'b0, active level of hsync_o
- V_SYNC_POLARITY, 1'b0, active level of vsync_o
- COORD_W, 11, coordinate width. Elaboration error if 2**COORD_W < TOTAL_WIDTH or < TOTAL_HEIGHT.

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- restart_i  in  1  synchronous frame restart
- line_cmp_en_i  in  1  line-compare enable
- line_cmp_i  in  COORD_W  compare line
- h_count_o  out  COORD_W  current pixel column
- v_count_o  out  COORD_W  current line
- visible_o  out  1  active display area
- hblank_o  out  1  h_count_o >= VISIBLE_WIDTH
- vblank_o  out  1  v_count_o >= VISIBLE_HEIGHT
- hsync_o  out  1  horizontal sync, at parameter polarity
- vsync_o  out  1  vertical sync, at parameter polarity
- end_of_line_o  out  1  strobe on the last pixel of each line
- end_of_frame_o  out  1  strobe on the last pixel of each frame
- frame_count_o  out  8  frame counter, wraps
- scanline_o  out  16  [15] vblank, [14] hblank, [13:11] zero, [10:0] v_count_o (zero-extended or truncated to 11 bits)
- line_irq_o  out  1  line-compare interrupt strobe

Behaviour:
- TOTAL_WIDTH = VISIBLE_WIDTH + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH. TOTAL_HEIGHT is the vertical equivalent.
- Horizontal order: visible, front porch, sync, back porch. Vertical order is the same.
- h_count_o increments every clk. At TOTAL_WIDTH-1 it wraps to 0 and v_count_o advances. v_count_o wraps to 0 after TOTAL_HEIGHT-1.
- All outputs are registers, decoded from next-state values so every flag matches the same-cycle h_count_o/v_count_o. Latency from coordinate to flag is zero.
- hsync_o is active when VISIBLE_WIDTH+H_FRONT_PORCH <= h < VISIBLE_WIDTH+H_FRONT_PORCH+H_SYNC_PULSE. vsync_o uses the same rule on v.
- visible_o = !hblank_o && !vblank_o.
- end_of_line_o = 1 when h = TOTAL_WIDTH-1. end_of_frame_o = 1 when end_of_line_o is high and v = TOTAL_HEIGHT-1.
- frame_count_o increments on the cycle after end_of_frame_o; 255 wraps to 0.
- Reset (async, any time, including mid-frame):
  - h_count_o = TOTAL_WIDTH-1, v_count_o = TOTAL_HEIGHT-1.
  - hblank_o = vblank_o = 1, visible_o = 0, both syncs inactive.
  - end_of_line_o, end_of_frame_o, line_irq_o = 0; frame_count_o = 0; scanline_o = {2'b11, 3'b0, (TOTAL_HEIGHT-1)[10:0]}.
  - First clk after deassertion yields (0,0) with no frame_count increment.
- restart_i high loads the reset position on the next clk; frame_count_o is held; strobes are forced 0 that cycle. restart_i held high keeps the counters parked there.
- restart_i has priority over normal counting.

Optional Feature:
- Macro: VTG_LINE_IRQ_EN.
- With the macro: line_irq_o pulses for exactly 1 cycle when line_cmp_en_i=1, v_count_o == line_cmp_i and h_count_o == VISIBLE_WIDTH (start of hblank). line_cmp_i and line_cmp_en_i are sampled that cycle. A value >= TOTAL_HEIGHT never fires. Suppressed while restart_i is asserted.
- Without the macro: line_irq_o is constant 0; compare inputs are ignored and unused.

Decomposition:
- Package xv gains:
  - SCANLINE_VBLANK_BIT = 15, SCANLINE_HBLANK_BIT = 14
  - frame_count_t (logic [7:0])
  - mode default values, which become defaults of this module's parameters.
- One natural sub-module: video_axis_cnt. A generic counter with params VISIBLE, FP, SYNC, BP, POL; inputs advance and restart; outputs count, blank, sync and last. It is instantiated once for H and once for V (V advance = H last).

Test Plan:
- Release reset_n with defaults -> next cycle h=0, v=0, visible_o=1, hsync_o=1, vsync_o=1, scanline_o=16'h0000.
- Free run line 0 -> hblank_o rises at h=640; hsync_o=0 for h=656..751 only; end_of_line_o high only at h=799; next cycle h=0, v=1.
- Run to v=490 -> vsync_o=0 for v=490,491 only. vblank_o=1 for v=480..524 and scanline_o[15]=1 there. At h=799, v=524, end_of_frame_o=1. frame_count_o goes 255 -> 0 across a frame boundary after preload by 256 frames.
- VTG_LINE_IRQ_EN defined, line_cmp_i=100, en=1 -> single line_irq_o pulse at v=100, h=640 each frame. en=0 -> none. line_cmp_i=600 -> none. Undefined -> never.
- restart_i pulse at h=300, v=200 -> next cycle h=799, v=524 with strobes 0, then (0,0); frame_count_o unchanged.
- Assert reset_n low mid-line at h=123 -> immediate (async) h=799, v=524, all strobes 0, frame_count_o=0.
